// File: rtl/game_pkg.sv
// Game-wide types and grid geometry defaults shared by the board logic
// and the mouse front end.
package game_pkg;

  localparam int DEF_GRID_X0   = 100;
  localparam int DEF_GRID_Y0   = 100;
  localparam int DEF_CELL_SIZE = 40;
  localparam int DEF_GRID_N    = 10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CALC     = 2'd1,
    ST_REQ      = 2'd2,
    ST_WAIT_REL = 2'd3
  } mouse_state_t;

endpackage

// File: rtl/vga_pkg.sv
// Display timing constants shared by the VGA pipeline and anything that
// has to clamp coordinates to the visible area.
package vga_pkg;

  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a counter debouncer: the output level
// follows the input only after DEBOUNCE_CYCLES consecutive differing samples.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b00;
      cnt     <= '0;
      btn_out <= 1'b0;
    end else begin
      sync <= {sync[0], btn_in};
      // Any sample equal to the current level restarts the stability count.
      if (sync[1] == btn_out) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        btn_out <= sync[1];
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mouse_ctl.sv
// Mouse front end: frame-stable cursor position, grid hit test, and a
// one-request-per-press cell selector computed by repeated subtraction.
module mouse_ctl
  import game_pkg::*;
  import vga_pkg::*;
#(
  parameter int GRID_X0         = DEF_GRID_X0,
  parameter int GRID_Y0         = DEF_GRID_Y0,
  parameter int CELL_SIZE       = DEF_CELL_SIZE,
  parameter int GRID_N          = DEF_GRID_N,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] xpos_raw,
  input  logic [11:0] ypos_raw,
  input  logic        left,
  input  logic        vblnk,
  input  logic        cell_ack,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        cursor_in_grid,
  output logic        cell_req,
  output logic [3:0]  cell_x,
  output logic [3:0]  cell_y,
  output logic [1:0]  state_dbg
);

  localparam logic [11:0] X_LO  = 12'(GRID_X0);
  localparam logic [11:0] X_HI  = 12'(GRID_X0 + GRID_N * CELL_SIZE);
  localparam logic [11:0] Y_LO  = 12'(GRID_Y0);
  localparam logic [11:0] Y_HI  = 12'(GRID_Y0 + GRID_N * CELL_SIZE);
  localparam logic [11:0] CELL  = 12'(CELL_SIZE);
  localparam logic [11:0] X_MAX = 12'(HOR_PIXELS - 1);
  localparam logic [11:0] Y_MAX = 12'(VER_PIXELS - 1);

  localparam int ARM_CYCLES = DEBOUNCE_CYCLES + 4;
  localparam int AW         = $clog2(ARM_CYCLES + 1);

  logic          vblnk_q, vblnk_qq;
  logic          btn_lvl, btn_q;
  logic          armed;
  logic [AW-1:0] arm_cnt;
  logic [11:0]   rem_x, rem_y;
  mouse_state_t  state;

  assign state_dbg = state;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (left),
    .btn_out(btn_lvl)
  );

  // Cursor only moves on a registered vblank rising edge so the overlay
  // never tears mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_q        <= 1'b0;
      vblnk_qq       <= 1'b0;
      xpos           <= '0;
      ypos           <= '0;
      cursor_in_grid <= 1'b0;
    end else begin
      vblnk_q  <= vblnk;
      vblnk_qq <= vblnk_q;
      if (vblnk_q && !vblnk_qq) begin
        xpos <= (xpos_raw > X_MAX) ? X_MAX : xpos_raw;
        ypos <= (ypos_raw > Y_MAX) ? Y_MAX : ypos_raw;
      end
      cursor_in_grid <= (xpos >= X_LO) && (xpos < X_HI) &&
                        (ypos >= Y_LO) && (ypos < Y_HI);
    end
  end

  // cell_req/cell_ack: cell_req rises with cell_x/cell_y valid and holds
  // them stable until cell_ack is sampled high; cell_ack is ignored at any
  // other time and cell_req drops on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      btn_q    <= 1'b0;
      armed    <= 1'b0;
      arm_cnt  <= '0;
      rem_x    <= '0;
      rem_y    <= '0;
      cell_x   <= '0;
      cell_y   <= '0;
      cell_req <= 1'b0;
    end else begin
      btn_q <= btn_lvl;
      // A button still held through reset must be seen released first.
      if (btn_lvl) begin
        arm_cnt <= '0;
      end else if (!armed) begin
        if (arm_cnt == AW'(ARM_CYCLES - 1)) armed <= 1'b1;
        else arm_cnt <= arm_cnt + AW'(1);
      end

      case (state)
        ST_IDLE: begin
          if (btn_lvl && !btn_q && armed) begin
            if (cursor_in_grid) begin
              state  <= ST_CALC;
              rem_x  <= xpos - X_LO;
              rem_y  <= ypos - Y_LO;
              cell_x <= '0;
              cell_y <= '0;
            end else begin
              state <= ST_WAIT_REL;
            end
          end
        end
        ST_CALC: begin
          if (rem_x >= CELL) begin
            rem_x  <= rem_x - CELL;
            cell_x <= cell_x + 4'd1;
          end
          if (rem_y >= CELL) begin
            rem_y  <= rem_y - CELL;
            cell_y <= cell_y + 4'd1;
          end
          if ((rem_x < CELL) && (rem_y < CELL)) begin
            state    <= ST_REQ;
            cell_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (cell_ack) begin
            cell_req <= 1'b0;
            state    <= ST_WAIT_REL;
          end
        end
        ST_WAIT_REL: begin
          if (!btn_lvl) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_ctl.sv
// Bench for mouse_ctl: directed boundary cases plus randomized presses,
// checked against a pixel-to-cell arithmetic model.
module tb_mouse_ctl;
  import game_pkg::*;

  localparam int GX0 = 100;
  localparam int GY0 = 100;
  localparam int CS  = 40;
  localparam int GN  = 10;

  logic        clk;
  logic        rst_n;
  logic [11:0] xpos_raw, ypos_raw;
  logic        left, vblnk, cell_ack;
  logic [11:0] xpos, ypos;
  logic        cursor_in_grid, cell_req;
  logic [3:0]  cell_x, cell_y;
  logic [1:0]  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int cur_x   = 0;
  int cur_y   = 0;
  logic [7:0] exp_q[$];

  mouse_ctl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .xpos_raw      (xpos_raw),
    .ypos_raw      (ypos_raw),
    .left          (left),
    .vblnk         (vblnk),
    .cell_ack      (cell_ack),
    .xpos          (xpos),
    .ypos          (ypos),
    .cursor_in_grid(cursor_in_grid),
    .cell_req      (cell_req),
    .cell_x        (cell_x),
    .cell_y        (cell_y),
    .state_dbg     (state_dbg)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // reference model
  function automatic bit in_grid(input int x, input int y);
    return (x >= GX0) && (x < GX0 + GN * CS) && (y >= GY0) && (y < GY0 + GN * CS);
  endfunction

  function automatic int clampi(input int v, input int hi);
    return (v > hi) ? hi : v;
  endfunction

  // drivers
  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_pos(input int x, input int y);
    xpos_raw = 12'(x);
    ypos_raw = 12'(y);
    step();
    vblnk = 1'b1;
    repeat (3) step();
    vblnk = 1'b0;
    repeat (3) step();
    cur_x = clampi(x, 799);
    cur_y = clampi(y, 599);
    check("xpos", xpos, cur_x);
    check("ypos", ypos, cur_y);
    check("in_grid", cursor_in_grid, in_grid(cur_x, cur_y));
  endtask

  task automatic press(input int hold, input bit rel_on_calc);
    int reqs = 0;
    int calc = 0;
    int since_req = 0;
    bit req_prev = 1'b0;
    bit exp_req;
    int ex, ey;
    logic [7:0] e;
    exp_req = in_grid(cur_x, cur_y);
    ex = (cur_x - GX0) / CS;
    ey = (cur_y - GY0) / CS;
    if (exp_req) exp_q.push_back({4'(ey), 4'(ex)});
    e = 8'h00;
    left = 1'b1;
    for (int c = 0; c < hold + 70; c++) begin
      step();
      if (c == hold) left = 1'b0;
      if (state_dbg == ST_CALC) begin
        calc++;
        if (rel_on_calc) left = 1'b0;
      end
      if (cell_ack) begin
        cell_ack = 1'b0;
        check("req_drop_after_ack", cell_req, 0);
      end else if (cell_req && !req_prev) begin
        reqs++;
        since_req = 0;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("cell_x", cell_x, e[3:0]);
          check("cell_y", cell_y, e[7:4]);
        end
      end else if (cell_req) begin
        since_req++;
        if (since_req == 5) begin
          check("cell_x_stable", cell_x, e[3:0]);
          check("cell_y_stable", cell_y, e[7:4]);
          cell_ack = 1'b1;
        end
      end
      req_prev = cell_req;
    end
    left = 1'b0;
    check("req_count", reqs, exp_req);
    if (exp_req) check("calc_cycles", calc, ((ex > ey) ? ex : ey) + 1);
    check("end_idle", state_dbg, ST_IDLE);
    exp_q.delete();
  endtask

  // stimulus
  initial begin
    int reqs;
    bit found;
    rst_n    = 1'b0;
    xpos_raw = '0;
    ypos_raw = '0;
    left     = 1'b0;
    vblnk    = 1'b0;
    cell_ack = 1'b0;
    repeat (3) step();
    check("rst_xpos", xpos, 0);
    check("rst_ypos", ypos, 0);
    check("rst_in_grid", cursor_in_grid, 0);
    check("rst_cell_req", cell_req, 0);
    check("rst_cell_x", cell_x, 0);
    check("rst_state", state_dbg, ST_IDLE);
    rst_n = 1'b1;
    repeat (30) step();

    set_pos(2000, 700);

    // no vblnk edge -> no movement, then in_grid lags position by one cycle
    xpos_raw = 12'd250;
    ypos_raw = 12'd180;
    repeat (6) step();
    check("hold_xpos", xpos, 799);
    check("hold_ypos", ypos, 599);
    vblnk = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      if (xpos == 12'd250) found = 1'b1;
    end
    check("vblnk_update_seen", found, 1);
    check("ypos_update", ypos, 180);
    check("in_grid_lag", cursor_in_grid, 0);
    step();
    check("in_grid_next", cursor_in_grid, 1);
    vblnk = 1'b0;
    repeat (3) step();
    cur_x = 250;
    cur_y = 180;

    press(20, 1'b0);
    press(100, 1'b0);

    // bouncing button never settles long enough
    reqs = 0;
    for (int i = 0; i < 8; i++) begin
      left = ~left;
      repeat (5) begin
        step();
        if (cell_req) reqs++;
      end
    end
    left = 1'b0;
    repeat (40) begin
      step();
      if (cell_req) reqs++;
    end
    check("bounce_no_req", reqs, 0);

    set_pos(499, 499); press(24, 1'b0);
    set_pos(500, 100); press(24, 1'b0);
    set_pos(50, 50);   press(24, 1'b0);
    set_pos(100, 100); press(24, 1'b0);

    set_pos(300, 300); press(40, 1'b1);

    cell_ack = 1'b1;
    step();
    cell_ack = 1'b0;
    repeat (3) step();
    check("idle_ack_req", cell_req, 0);
    check("idle_ack_state", state_dbg, ST_IDLE);
    set_pos(180, 420); press(22, 1'b0);

    for (int i = 0; i < 10; i++) begin
      int rx, ry;
      rx = $urandom_range(0, 900);
      ry = $urandom_range(0, 700);
      if ($urandom_range(0, 3) != 0) begin
        rx = $urandom_range(60, 540);
        ry = $urandom_range(60, 540);
      end
      set_pos(rx, ry);
      press($urandom_range(20, 40), 1'b0);
    end

    // reset while a request is pending, button kept held
    set_pos(260, 260);
    left  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      step();
      if (cell_req) found = 1'b1;
    end
    check("pre_rst_req", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req", cell_req, 0);
    check("async_rst_state", state_dbg, ST_IDLE);
    check("async_rst_xpos", xpos, 0);
    check("async_rst_cell_x", cell_x, 0);
    step();
    step();
    rst_n = 1'b1;
    cur_x = 0;
    cur_y = 0;
    reqs  = 0;
    repeat (80) begin
      step();
      if (cell_req) reqs++;
    end
    check("held_after_rst_no_req", reqs, 0);
    left = 1'b0;
    repeat (60) step();
    check("post_rst_state", state_dbg, ST_IDLE);

    set_pos(460, 140);
    press(26, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
